// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: 0x55 header, 12 latched payload bytes, 0xAA tail,
// sent 8N1 LSB-first with optional idle-high gap bits between bytes.
module uart_mult_byte_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int GAP_BITS = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_req,
    input  logic [95:0] tx_payload,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        send_done,
    output logic [3:0]  byte_idx
);

    localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
    localparam logic [15:0] GAP_LAST  = (GAP_BITS > 0) ? 16'(GAP_BITS * BPS_CNT - 1) : 16'd0;
    localparam logic [3:0]  LAST_BYTE = 4'd13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state_r;
    logic [95:0] payload_r;
    logic [2:0]  bit_cnt_r;
    logic [15:0] clk_cnt_r;
    logic [7:0]  cur_byte_s;
    logic        bit_end_s;
    logic        gap_end_s;

    // Indices 14..15 cannot occur; they idle the line rather than expose payload.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [95:0] pl);
        logic [7:0] res;
        case (idx)
            4'd0:    res = 8'h55;
            4'd13:   res = 8'hAA;
            4'd14:   res = 8'hFF;
            4'd15:   res = 8'hFF;
            default: res = pl[{idx - 4'd1, 3'b000} +: 8];
        endcase
        return res;
    endfunction

    // Current frame byte and bit-period / gap-period terminal counts.
    always_comb begin
        cur_byte_s = frame_byte(byte_idx, payload_r);
        bit_end_s  = (clk_cnt_r == BIT_LAST);
        gap_end_s  = (clk_cnt_r == GAP_LAST);
    end

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r   <= IDLE;
            payload_r <= 96'd0;
            bit_cnt_r <= 3'd0;
            clk_cnt_r <= 16'd0;
            uart_txd  <= 1'b1;
            tx_busy   <= 1'b0;
            send_done <= 1'b0;
            byte_idx  <= 4'd0;
        end else begin
            send_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= 16'd0;
                    if (send_req) begin
                        payload_r <= tx_payload;
                        byte_idx  <= 4'd0;
                        tx_busy   <= 1'b1;
                        uart_txd  <= 1'b0;
                        state_r   <= START;
                    end else begin
                        uart_txd  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= 16'd0;
                        bit_cnt_r <= 3'd0;
                        uart_txd  <= cur_byte_s[0];
                        state_r   <= DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= 16'd0;
                        if (bit_cnt_r == 3'd7) begin
                            uart_txd <= 1'b1;
                            state_r  <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            uart_txd  <= cur_byte_s[bit_cnt_r + 3'd1];
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= 16'd0;
                        if (byte_idx == LAST_BYTE) begin
                            send_done <= 1'b1;
                            tx_busy   <= 1'b0;
                            byte_idx  <= 4'd0;
                            state_r   <= IDLE;
                        end else if (GAP_BITS > 0) begin
                            state_r   <= GAP;
                        end else begin
                            byte_idx  <= byte_idx + 4'd1;
                            uart_txd  <= 1'b0;
                            state_r   <= START;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        clk_cnt_r <= 16'd0;
                        byte_idx  <= byte_idx + 4'd1;
                        uart_txd  <= 1'b0;
                        state_r   <= START;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= 16'd0;
                    uart_txd  <= 1'b1;
                    tx_busy   <= 1'b0;
                    byte_idx  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Randomized self-checking bench for uart_mult_byte_tx against a frame-timing model.
module tb_uart_mult_byte_tx;

    localparam int CLK_FREQ = 400;
    localparam int UART_BPS = 100;
    localparam int GAP_BITS = 2;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int BYTE_T   = 10 * BPS + GAP_BITS * BPS;
    localparam int TOTAL    = 14 * 10 * BPS + 13 * GAP_BITS * BPS;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        send_req   = 1'b0;
    logic [95:0] tx_payload = 96'd0;
    logic        uart_txd;
    logic        tx_busy;
    logic        send_done;
    logic [3:0]  byte_idx;

    int n_cmp = 0;
    int n_err = 0;

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .send_req   (send_req),
        .tx_payload (tx_payload),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .send_done  (send_done),
        .byte_idx   (byte_idx)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int b, input logic [95:0] pl);
        if (b == 0)       return 8'h55;
        else if (b >= 13) return 8'hAA;
        else              return pl[8*(b-1) +: 8];
    endfunction

    // Send one frame from the current (idle) negedge and check it cycle by cycle.
    // req_t: extra in-frame request cycle; req_at_done: request on the done edge;
    // rst_t: cycle to pulse reset (abort), or -1.
    task automatic do_frame(input logic [95:0] pl, input int req_t, input bit req_at_done,
                            input int rst_t);
        logic [7:0] dec;
        logic [7:0] eb;
        int b, r, p, early_done, lows;
        send_req   = 1'b1;
        tx_payload = pl;
        @(negedge sys_clk);
        send_req   = 1'b0;
        early_done = 0;
        dec        = 8'd0;
        for (int t = 0; t <= TOTAL; t++) begin
            if (t == 1) tx_payload = {$urandom, $urandom, $urandom};
            b  = t / BYTE_T;
            r  = t % BYTE_T;
            eb = exp_byte(b, pl);
            if (t == 0) begin
                chk("start_edge_txd", 32'(uart_txd), 32'd0);
                chk("start_edge_busy", 32'(tx_busy), 32'd1);
            end
            if (t == TOTAL) begin
                chk("done_pulse", 32'(send_done), 32'd1);
                chk("done_busy", 32'(tx_busy), 32'd0);
                chk("done_idx", 32'(byte_idx), 32'd0);
                chk("done_txd", 32'(uart_txd), 32'd1);
                chk("early_done", 32'(early_done), 32'd0);
            end else begin
                if (send_done) early_done++;
                if (r < 10 * BPS && (r % BPS) == BPS / 2) begin
                    p = r / BPS;
                    if (p == 0) begin
                        chk("start_bit", 32'(uart_txd), 32'd0);
                        chk("byte_idx", 32'(byte_idx), 32'(b));
                        chk("busy", 32'(tx_busy), 32'd1);
                    end else if (p <= 8) begin
                        dec[p-1] = uart_txd;
                    end else begin
                        chk("stop_bit", 32'(uart_txd), 32'd1);
                        chk("byte", 32'(dec), 32'(eb));
                    end
                end else if (r == 10 * BPS + BPS) begin
                    chk("gap_idle", 32'(uart_txd), 32'd1);
                end
            end
            send_req = (t == req_t) || (req_at_done && t == TOTAL - 1);
            if (t == rst_t) begin
                send_req  = 1'b0;
                sys_rst_n = 1'b0;
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
                chk("abort_txd", 32'(uart_txd), 32'd1);
                chk("abort_busy", 32'(tx_busy), 32'd0);
                chk("abort_idx", 32'(byte_idx), 32'd0);
                chk("abort_done", 32'(send_done), 32'd0);
                early_done = 0;
                lows       = 0;
                for (int k = 0; k < 2 * BYTE_T; k++) begin
                    @(negedge sys_clk);
                    if (send_done) early_done++;
                    if (!uart_txd) lows++;
                end
                chk("abort_no_done", 32'(early_done), 32'd0);
                chk("abort_line_idle", 32'(lows), 32'd0);
                return;
            end
            @(negedge sys_clk);
        end
        send_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(send_done), 32'd0);
        chk("rst_idx", 32'(byte_idx), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Counting payload, re-request mid byte 5, request on the done cycle.
        do_frame(96'h0C0B0A09_08070605_04030201, 5 * BYTE_T + 5 * BPS, 1'b1, -1);
        // Back-to-back frame with alternating A5/5A bytes.
        do_frame(96'h5AA55AA5_5AA55AA5_5AA55AA5, -1, 1'b0, -1);
        // Reset during byte 7 data bit 3, then a clean frame.
        do_frame({$urandom, $urandom, $urandom}, -1, 1'b0, 7 * BYTE_T + 4 * BPS + 1);
        do_frame({$urandom, $urandom, $urandom}, -1, 1'b0, -1);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge sys_clk);
                chk("idle_txd", 32'(uart_txd), 32'd1);
            end
            do_frame({$urandom, $urandom, $urandom}, int'($urandom_range(0, TOTAL - 2)),
                     1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
